// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the parametrised accumulator CPU.
//   - Opcode encodings (3-bit opcode field at the top of every instruction)
//   - Control FSM state encoding
//   - Instruction field slicing helpers that work for any address width up
//     to MAX_ADDR_W. Callers zero-extend their instruction word to
//     MAX_INSN_W and pass their own address width.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int OPCODE_W   = 3;
  localparam int MAX_ADDR_W = 16;
  localparam int MAX_INSN_W = OPCODE_W + MAX_ADDR_W;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  // Opcode sits directly above the address field.
  function automatic logic [OPCODE_W-1:0] insn_opcode(
    input logic [MAX_INSN_W-1:0] insn,
    input int                    addr_w
  );
    return OPCODE_W'(insn >> addr_w);
  endfunction

  // Address field is the low addr_w bits; callers truncate to their width.
  function automatic logic [MAX_ADDR_W-1:0] insn_addr(
    input logic [MAX_INSN_W-1:0] insn,
    input int                    addr_w
  );
    logic [MAX_INSN_W-1:0] mask;
    mask = ~({MAX_INSN_W{1'b1}} << addr_w);
    return MAX_ADDR_W'(insn & mask);
  endfunction

endpackage

// File: rtl/accum_alu.sv
// ---------------------------------------------------------------------------
// accum_alu
// Purely combinational ALU for the accumulator CPU.
// Ports:
//   opcode    in  3       current instruction opcode
//   acc       in  DATA_W  accumulator value
//   mem       in  DATA_W  DMEM operand word
//   carry_in  in  1       current carry flag (held by non-ADD opcodes)
//   result    out DATA_W  next accumulator value
//   carry_out out 1       next carry flag
// Opcodes that do not touch the accumulator return acc unchanged.
// ---------------------------------------------------------------------------
module accum_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]   mem,
  input  logic                carry_in,
  output logic [DATA_W-1:0]   result,
  output logic                carry_out
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum       = {1'b0, acc} + {1'b0, mem};
    result    = acc;
    carry_out = carry_in;
    case (opcode)
      OP_ADD: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      OP_AND:  result = acc & mem;
      OP_XOR:  result = acc ^ mem;
      OP_LDA:  result = mem;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/accum_cpu_core.sv
// ---------------------------------------------------------------------------
// accum_cpu_core
// Parametrised multi-cycle accumulator CPU with a valid/ready program-load
// port that fills either instruction or data memory.
// Ports:
//   Clk       in   1       clock, all state updates on rising edge
//   Reset     in   1       synchronous active-high reset
//   Load      in   1       level request for program-load mode
//   Ld_sel    in   1       0 = write IMEM, 1 = write DMEM (per beat)
//   Ld_valid  in   1       load beat valid
//   Ld_data   in   LD_W    load word (IMEM uses low INSN_W, DMEM low DATA_W)
//   Ld_ready  out  1       beat accepted this cycle (only while loading)
//   Start     in   1       begin/resume execution from IDLE or HALT
//   Halted    out  1       core is in HALT
//   Busy      out  1       instruction in flight (FETCH/EXEC/WB)
//   Pc        out  ADDR_W  program counter
//   Ir        out  INSN_W  current instruction {opcode, addr}
//   Acc       out  DATA_W  accumulator
//   Carry     out  1       carry out of the last ADD
//   Zero      out  1       Acc == 0
//   Dm_rdata  out  DATA_W  DMEM word at Ir address, captured in EXEC
// Every instruction runs FETCH -> EXEC -> WB. Memories are not reset.
// ---------------------------------------------------------------------------
module accum_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 5,
  localparam int INSN_W = OPCODE_W + ADDR_W,
  localparam int LD_W   = (DATA_W > INSN_W) ? DATA_W : INSN_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic              Ld_sel,
  input  logic              Ld_valid,
  input  logic [LD_W-1:0]   Ld_data,
  output logic              Ld_ready,
  input  logic              Start,
  output logic              Halted,
  output logic              Busy,
  output logic [ADDR_W-1:0] Pc,
  output logic [INSN_W-1:0] Ir,
  output logic [DATA_W-1:0] Acc,
  output logic              Carry,
  output logic              Zero,
  output logic [DATA_W-1:0] Dm_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ld_ptr_q, ld_ptr_d;
  logic [INSN_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                carry_q, carry_d;

  logic [INSN_W-1:0]   imem [DEPTH];
  logic [DATA_W-1:0]   dmem [DEPTH];

  logic                imem_we;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_waddr;
  logic [DATA_W-1:0]   dmem_wdata;

  logic [OPCODE_W-1:0] ir_op;
  logic [ADDR_W-1:0]   ir_addr;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;

  assign ir_op   = insn_opcode(MAX_INSN_W'(ir_q), ADDR_W);
  assign ir_addr = ADDR_W'(insn_addr(MAX_INSN_W'(ir_q), ADDR_W));

  // The ALU works on the operand captured in EXEC, so WB sees a stable word.
  accum_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .opcode   (ir_op),
    .acc      (acc_q),
    .mem      (dm_rdata_q),
    .carry_in (carry_q),
    .result   (alu_result),
    .carry_out(alu_carry)
  );

  // Ready is qualified with Load so that the cycle leaving LOAD never
  // handshakes a beat.
  assign Ld_ready = (state_q == ST_LOAD) && Load;
  assign Halted   = (state_q == ST_HALT);
  assign Busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC) ||
                    (state_q == ST_WB);
  assign Pc       = pc_q;
  assign Ir       = ir_q;
  assign Acc      = acc_q;
  assign Carry    = carry_q;
  assign Zero     = (acc_q == '0);
  assign Dm_rdata = dm_rdata_q;

  // Next-state, datapath updates and memory write strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ld_ptr_d   = ld_ptr_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    dm_rdata_d = dm_rdata_q;
    carry_d    = carry_q;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    dmem_waddr = ir_addr;
    dmem_wdata = acc_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Load) begin
          state_d  = ST_LOAD;
          ld_ptr_d = '0;
        end else if (Start) begin
          state_d = ST_FETCH;
        end
      end

      ST_LOAD: begin
        if (!Load) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end else if (Ld_valid) begin
          // Pointer is shared by both memories and wraps naturally.
          ld_ptr_d = ld_ptr_q + ADDR_W'(1);
          if (Ld_sel) begin
            dmem_we    = 1'b1;
            dmem_waddr = ld_ptr_q;
            dmem_wdata = Ld_data[DATA_W-1:0];
          end else begin
            imem_we = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        dm_rdata_d = dmem[ir_addr];
        state_d    = ST_WB;
      end

      ST_WB: begin
        pc_d    = pc_q + ADDR_W'(1);
        acc_d   = alu_result;
        carry_d = alu_carry;
        case (ir_op)
          OP_SKZ:  if (acc_q == '0) pc_d = pc_q + ADDR_W'(2);
          OP_JMP:  pc_d = ir_addr;
          OP_STO:  dmem_we = 1'b1;
          default: ;
        endcase
        // The instruction always retires before a pending load takes over.
        if (Load) begin
          state_d  = ST_LOAD;
          ld_ptr_d = '0;
        end else if (ir_op == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A reset cycle must never disturb memory contents.
    if (Reset) begin
      imem_we = 1'b0;
      dmem_we = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ld_ptr_q   <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      dm_rdata_q <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ld_ptr_q   <= ld_ptr_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      dm_rdata_q <= dm_rdata_d;
      carry_q    <= carry_d;
    end
  end

  // Memories carry no reset so they survive Reset.
  always_ff @(posedge Clk) begin
    if (imem_we) imem[ld_ptr_q] <= Ld_data[INSN_W-1:0];
    if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
  end

endmodule

// File: tb/tb_accum_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_accum_cpu_core
// Directed bench for accum_cpu_core. Instance dut_a is the 8-bit/5-bit
// build; dut_b is the 16-bit/6-bit build. Inputs change and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_accum_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_reset, a_load, a_ld_sel, a_ld_valid, a_start;
  logic [7:0] a_ld_data;
  logic       a_ld_ready, a_halted, a_busy, a_carry, a_zero;
  logic [4:0] a_pc;
  logic [7:0] a_ir, a_acc, a_dm;

  logic        b_reset, b_load, b_ld_sel, b_ld_valid, b_start;
  logic [15:0] b_ld_data;
  logic        b_ld_ready, b_halted, b_busy, b_carry, b_zero;
  logic [5:0]  b_pc;
  logic [8:0]  b_ir;
  logic [15:0] b_acc, b_dm;

  logic [7:0]  a_buf [64];

  accum_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut_a (
    .Clk(clk), .Reset(a_reset), .Load(a_load), .Ld_sel(a_ld_sel),
    .Ld_valid(a_ld_valid), .Ld_data(a_ld_data), .Ld_ready(a_ld_ready),
    .Start(a_start), .Halted(a_halted), .Busy(a_busy), .Pc(a_pc), .Ir(a_ir),
    .Acc(a_acc), .Carry(a_carry), .Zero(a_zero), .Dm_rdata(a_dm)
  );

  accum_cpu_core #(.DATA_W(16), .ADDR_W(6)) dut_b (
    .Clk(clk), .Reset(b_reset), .Load(b_load), .Ld_sel(b_ld_sel),
    .Ld_valid(b_ld_valid), .Ld_data(b_ld_data), .Ld_ready(b_ld_ready),
    .Start(b_start), .Halted(b_halted), .Busy(b_busy), .Pc(b_pc), .Ir(b_ir),
    .Acc(b_acc), .Carry(b_carry), .Zero(b_zero), .Dm_rdata(b_dm)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Enter LOAD, stream n words from a_buf back-to-back, return to IDLE.
  task automatic a_load_session(input logic sel, input int n);
    a_load = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      a_ld_sel   = sel;
      a_ld_valid = 1'b1;
      a_ld_data  = a_buf[i];
      #1;
      checks++; if (a_ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_ready beat %0d got=%b exp=1", i, a_ld_ready); end
      tick();
    end
    a_ld_valid = 1'b0;
    a_load     = 1'b0;
    tick();
  endtask

  task automatic a_start_pulse();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_load = 0; a_ld_sel = 0; a_ld_valid = 0; a_ld_data = '0; a_start = 0;
    b_reset = 1'b1; b_load = 0; b_ld_sel = 0; b_ld_valid = 0; b_ld_data = '0; b_start = 0;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;
    checks++; if (a_pc !== 5'd0)    begin errors++; $display("[TB] FAIL reset_pc got=%h exp=0", a_pc); end
    checks++; if (a_acc !== 8'd0)   begin errors++; $display("[TB] FAIL reset_acc got=%h exp=0", a_acc); end
    checks++; if (a_ir !== 8'd0)    begin errors++; $display("[TB] FAIL reset_ir got=%h exp=0", a_ir); end
    checks++; if (a_carry !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry got=%b exp=0", a_carry); end
    checks++; if (a_dm !== 8'd0)    begin errors++; $display("[TB] FAIL reset_dm got=%h exp=0", a_dm); end
    checks++; if (a_halted !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_state halted=%b busy=%b exp=0/0", a_halted, a_busy); end
    checks++; if (a_ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_ready got=%b exp=0", a_ld_ready); end
    checks++; if (a_zero !== 1'b1)  begin errors++; $display("[TB] FAIL reset_zero got=%b exp=1", a_zero); end
    checks++; if (b_pc !== 6'd0 || b_acc !== 16'd0) begin errors++; $display("[TB] FAIL reset_wide pc=%h acc=%h exp=0/0", b_pc, b_acc); end
  endtask

  // LDA 0, ADD 1, STO 2, HLT 2 (then XOR 1, HLT 0 for the resume test).
  task automatic test_program();
    a_buf[0] = 8'hF0; a_buf[1] = 8'h20;
    a_load_session(1'b1, 2);
    a_buf[0] = 8'hA0; a_buf[1] = 8'h41; a_buf[2] = 8'hC2;
    a_buf[3] = 8'h02; a_buf[4] = 8'h81; a_buf[5] = 8'h00;
    a_load_session(1'b0, 6);
    checks++; if (a_pc !== 5'd0 || a_halted !== 1'b0) begin errors++; $display("[TB] FAIL prog_idle pc=%h halted=%b exp=0/0", a_pc, a_halted); end
    a_start_pulse();
    checks++; if (a_busy !== 1'b1) begin errors++; $display("[TB] FAIL prog_busy got=%b exp=1", a_busy); end
    repeat (11) tick();
    checks++; if (a_halted !== 1'b0) begin errors++; $display("[TB] FAIL prog_early_halt got=%b exp=0", a_halted); end
    tick();
    checks++; if (a_halted !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("[TB] FAIL prog_halt halted=%b busy=%b exp=1/0", a_halted, a_busy); end
    checks++; if (a_acc !== 8'h10)  begin errors++; $display("[TB] FAIL prog_acc got=%h exp=10", a_acc); end
    checks++; if (a_carry !== 1'b1) begin errors++; $display("[TB] FAIL prog_carry got=%b exp=1", a_carry); end
    checks++; if (a_zero !== 1'b0)  begin errors++; $display("[TB] FAIL prog_zero got=%b exp=0", a_zero); end
    checks++; if (a_pc !== 5'd4)    begin errors++; $display("[TB] FAIL prog_pc got=%h exp=4", a_pc); end
    checks++; if (a_dm !== 8'h10)   begin errors++; $display("[TB] FAIL prog_dmem2 got=%h exp=10", a_dm); end
    checks++; if (a_ir !== 8'h02)   begin errors++; $display("[TB] FAIL prog_ir got=%h exp=02", a_ir); end
  endtask

  // Resume from HALT at Pc=4 with Start held through the busy cycles.
  task automatic test_resume();
    a_start = 1'b1;
    tick();
    checks++; if (a_busy !== 1'b1 || a_halted !== 1'b0) begin errors++; $display("[TB] FAIL resume_fetch busy=%b halted=%b exp=1/0", a_busy, a_halted); end
    tick();
    checks++; if (a_ir !== 8'h81) begin errors++; $display("[TB] FAIL resume_ir got=%h exp=81", a_ir); end
    tick();
    a_start = 1'b0;
    tick();
    checks++; if (a_pc !== 5'd5)    begin errors++; $display("[TB] FAIL resume_pc got=%h exp=5", a_pc); end
    checks++; if (a_acc !== 8'h30)  begin errors++; $display("[TB] FAIL resume_xor got=%h exp=30", a_acc); end
    checks++; if (a_carry !== 1'b1) begin errors++; $display("[TB] FAIL resume_carry_held got=%b exp=1", a_carry); end
    repeat (3) tick();
    checks++; if (a_halted !== 1'b1 || a_pc !== 5'd6) begin errors++; $display("[TB] FAIL resume_halt halted=%b pc=%h exp=1/6", a_halted, a_pc); end
    checks++; if (a_dm !== 8'hF0)   begin errors++; $display("[TB] FAIL resume_dm got=%h exp=F0", a_dm); end
  endtask

  // LDA 0, AND 0, JMP 7, SKZ, HLT, LDA 1, JMP 3, JMP 3 -> Pc trace below.
  task automatic test_skz_jmp();
    logic [4:0] exp_pc [9];
    exp_pc = '{5'd1, 5'd2, 5'd7, 5'd3, 5'd5, 5'd6, 5'd3, 5'd4, 5'd5};
    a_buf[0] = 8'h00; a_buf[1] = 8'h01;
    a_load_session(1'b1, 2);
    a_buf[0] = 8'hA0; a_buf[1] = 8'h60; a_buf[2] = 8'hE7; a_buf[3] = 8'h20;
    a_buf[4] = 8'h00; a_buf[5] = 8'hA1; a_buf[6] = 8'hE3; a_buf[7] = 8'hE3;
    a_load_session(1'b0, 8);
    a_start_pulse();
    for (int k = 0; k < 9; k++) begin
      repeat (3) tick();
      checks++; if (a_pc !== exp_pc[k]) begin errors++; $display("[TB] FAIL skz_jmp_pc step %0d got=%h exp=%h", k, a_pc, exp_pc[k]); end
    end
    checks++; if (a_halted !== 1'b1 || a_acc !== 8'h01) begin errors++; $display("[TB] FAIL skz_jmp_end halted=%b acc=%h exp=1/01", a_halted, a_acc); end
  endtask

  // 33 back-to-back IMEM beats: beat 32 overwrites address 0 with JMP 30.
  task automatic test_wrap();
    a_buf[0] = 8'h00; a_buf[1] = 8'h01; a_buf[2] = 8'hFF;
    a_load_session(1'b1, 3);
    for (int i = 0; i < 33; i++) a_buf[i] = 8'h00;
    a_buf[2] = 8'h42; a_buf[30] = 8'hA0; a_buf[31] = 8'h20; a_buf[32] = 8'hFE;
    a_load_session(1'b0, 33);
    a_start_pulse();
    repeat (3) tick();
    checks++; if (a_pc !== 5'd30) begin errors++; $display("[TB] FAIL wrap_jmp got=%h exp=1e", a_pc); end
    repeat (3) tick();
    checks++; if (a_pc !== 5'd31 || a_zero !== 1'b1) begin errors++; $display("[TB] FAIL wrap_lda pc=%h zero=%b exp=1f/1", a_pc, a_zero); end
    repeat (3) tick();
    checks++; if (a_pc !== 5'd1) begin errors++; $display("[TB] FAIL wrap_skz31 got=%h exp=01", a_pc); end
    repeat (3) tick();
    checks++; if (a_halted !== 1'b1 || a_pc !== 5'd2) begin errors++; $display("[TB] FAIL wrap_halt halted=%b pc=%h exp=1/02", a_halted, a_pc); end
  endtask

  // Load raised during EXEC of ADD 2 (0 + FF); exit beat must be dropped.
  task automatic test_load_during_exec();
    a_start_pulse();
    tick();
    checks++; if (a_ir !== 8'h42) begin errors++; $display("[TB] FAIL lde_ir got=%h exp=42", a_ir); end
    a_load = 1'b1;
    tick();
    checks++; if (a_busy !== 1'b1 || a_ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL lde_wb busy=%b ready=%b exp=1/0", a_busy, a_ld_ready); end
    tick();
    checks++; if (a_ld_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("[TB] FAIL lde_load ready=%b busy=%b exp=1/0", a_ld_ready, a_busy); end
    checks++; if (a_acc !== 8'hFF || a_carry !== 1'b0) begin errors++; $display("[TB] FAIL lde_add acc=%h carry=%b exp=ff/0", a_acc, a_carry); end
    checks++; if (a_pc !== 5'd3) begin errors++; $display("[TB] FAIL lde_pc got=%h exp=03", a_pc); end
    a_load = 1'b0; a_ld_valid = 1'b1; a_ld_sel = 1'b0; a_ld_data = 8'h00;
    #1;
    checks++; if (a_ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL lde_exit_ready got=%b exp=0", a_ld_ready); end
    tick();
    a_ld_valid = 1'b0;
    checks++; if (a_pc !== 5'd0) begin errors++; $display("[TB] FAIL lde_exit_pc got=%h exp=0", a_pc); end
    a_start_pulse();
    repeat (3) tick();
    checks++; if (a_pc !== 5'd30) begin errors++; $display("[TB] FAIL lde_no_write pc=%h exp=1e", a_pc); end
    repeat (9) tick();
    checks++; if (a_halted !== 1'b1 || a_pc !== 5'd2) begin errors++; $display("[TB] FAIL lde_halt halted=%b pc=%h exp=1/02", a_halted, a_pc); end
  endtask

  // Reset during WB of ADD 2 (which would give FF) from HALT at Pc=2.
  task automatic test_reset_mid();
    a_start_pulse();
    tick(); tick();
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    checks++; if (a_halted !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_state halted=%b busy=%b exp=0/0", a_halted, a_busy); end
    checks++; if (a_pc !== 5'd0)   begin errors++; $display("[TB] FAIL rmid_pc got=%h exp=0", a_pc); end
    checks++; if (a_acc !== 8'h00) begin errors++; $display("[TB] FAIL rmid_acc got=%h exp=0", a_acc); end
    checks++; if (a_ir !== 8'h00 || a_dm !== 8'h00) begin errors++; $display("[TB] FAIL rmid_ir_dm ir=%h dm=%h exp=0/0", a_ir, a_dm); end
    a_start_pulse();
    repeat (3) tick();
    checks++; if (a_pc !== 5'd30) begin errors++; $display("[TB] FAIL rmid_mem_kept pc=%h exp=1e", a_pc); end
  endtask

  // Program of test_program on the 16-bit/6-bit build.
  task automatic test_wide();
    logic [15:0] dwords [2];
    logic [15:0] iwords [4];
    dwords = '{16'hFFF0, 16'h0020};
    iwords = '{16'h0140, 16'h0081, 16'h0182, 16'h0002};
    b_load = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin b_ld_sel = 1'b1; b_ld_valid = 1'b1; b_ld_data = dwords[i]; tick(); end
    b_ld_valid = 1'b0; b_load = 1'b0; tick();
    b_load = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin b_ld_sel = 1'b0; b_ld_valid = 1'b1; b_ld_data = iwords[i]; tick(); end
    b_ld_valid = 1'b0; b_load = 1'b0; tick();
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (11) tick();
    checks++; if (b_halted !== 1'b0) begin errors++; $display("[TB] FAIL wide_early_halt got=%b exp=0", b_halted); end
    tick();
    checks++; if (b_halted !== 1'b1)   begin errors++; $display("[TB] FAIL wide_halt got=%b exp=1", b_halted); end
    checks++; if (b_acc !== 16'h0010)  begin errors++; $display("[TB] FAIL wide_acc got=%h exp=0010", b_acc); end
    checks++; if (b_carry !== 1'b1)    begin errors++; $display("[TB] FAIL wide_carry got=%b exp=1", b_carry); end
    checks++; if (b_pc !== 6'd4)       begin errors++; $display("[TB] FAIL wide_pc got=%h exp=4", b_pc); end
    checks++; if (b_dm !== 16'h0010)   begin errors++; $display("[TB] FAIL wide_dmem2 got=%h exp=0010", b_dm); end
    checks++; if (b_ir !== 9'h002)     begin errors++; $display("[TB] FAIL wide_ir got=%h exp=002", b_ir); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_resume();
    test_skz_jmp();
    test_wrap();
    test_load_during_exec();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
